// File: rtl/case_conv_arbiter.sv
// ---------------------------------------------------------------------------
// case_conv_arbiter: round-robin two-source message arbiter with ASCII
// upper/lower case conversion. Optional stats via CASE_CONV_STATS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module case_conv_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [7:0]  in0_data,
  input  logic        in0_last,
  input  logic        mode0,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [7:0]  in1_data,
  input  logic        in1_last,
  input  logic        mode1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_src,
  output logic        err,
  output logic [15:0] stat_conv,
  output logic [15:0] stat_msgs
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            err_q, err_d;
  logic            out_valid_q;
  logic [7:0]      out_data_q;
  logic            out_last_q;
  logic            out_src_q;

  logic            w_sel_valid;
  logic [7:0]      w_sel_data;
  logic            w_sel_last;
  logic            w_slot_free;
  logic            w_acc;
  logic            w_wd_fire;

  // True when the byte lies in the letter range that the current mode changes.
  function automatic logic case_hit(input logic [7:0] b, input logic up);
    if (up) return (b >= 8'h61) && (b <= 8'h7A);
    else    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic [7:0] conv_byte(input logic [7:0] b, input logic up);
    logic [7:0] r;
    r = b;
    if (case_hit(b, up)) r[5] = ~up;
    return r;
  endfunction

  always_comb begin
    w_sel_valid = (state_q == GRANT1) ? in1_valid : in0_valid;
    w_sel_data  = (state_q == GRANT1) ? in1_data  : in0_data;
    w_sel_last  = (state_q == GRANT1) ? in1_last  : in0_last;
    w_slot_free = out_ready | ~out_valid_q;
    in0_ready   = (state_q == GRANT0) & w_slot_free;
    in1_ready   = (state_q == GRANT1) & w_slot_free;
    w_acc       = (state_q != IDLE) & w_sel_valid & w_slot_free;
    w_wd_fire   = (TIMEOUT != 0) && (state_q != IDLE) && !w_sel_valid &&
                  ((32'(idle_cnt_q) + 32'd1) == 32'(TIMEOUT));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    idle_cnt_d   = idle_cnt_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        // Port 0 wins a tie only when port 1 was served last.
        if (in0_valid && (!in1_valid || last_grant_q)) begin
          state_d      = GRANT0;
          mode_d       = mode0;
          last_grant_d = 1'b0;
        end else if (in1_valid) begin
          state_d      = GRANT1;
          mode_d       = mode1;
          last_grant_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (w_acc) begin
          idle_cnt_d = '0;
          if (w_sel_last) state_d = IDLE;
        end else if (!w_sel_valid) begin
          if (w_wd_fire) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mode_q       <= 1'b0;
      idle_cnt_q   <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_src_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      idle_cnt_q   <= idle_cnt_d;
      err_q        <= err_d;
      if (w_acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= conv_byte(w_sel_data, mode_q);
        out_last_q  <= w_sel_last;
        out_src_q   <= (state_q == GRANT1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign err       = err_q;

`ifdef CASE_CONV_STATS_EN
  logic [15:0] stat_conv_q;
  logic [15:0] stat_msgs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conv_q <= 16'h0000;
      stat_msgs_q <= 16'h0000;
    end else begin
      if (w_acc && case_hit(w_sel_data, mode_q) && (stat_conv_q != 16'hFFFF))
        stat_conv_q <= stat_conv_q + 16'd1;
      if (w_acc && w_sel_last && (stat_msgs_q != 16'hFFFF))
        stat_msgs_q <= stat_msgs_q + 16'd1;
    end
  end

  assign stat_conv = stat_conv_q;
  assign stat_msgs = stat_msgs_q;
`else
  assign stat_conv = 16'h0000;
  assign stat_msgs = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_case_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_case_conv_arbiter: directed self-checking bench for case_conv_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_case_conv_arbiter;

`ifdef CASE_CONV_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_valid = 1'b0, in0_last = 1'b0, mode0 = 1'b0;
  logic        in1_valid = 1'b0, in1_last = 1'b0, mode1 = 1'b0;
  logic [7:0]  in0_data = 8'h00, in1_data = 8'h00;
  logic        in0_ready, in1_ready;
  logic        out_valid, out_last, out_src, err;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [15:0] stat_conv, stat_msgs;

  int vecs = 0;
  int errs = 0;

  case_conv_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in0_last(in0_last), .mode0(mode0),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .in1_last(in1_last), .mode1(mode1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .err(err),
    .stat_conv(stat_conv), .stat_msgs(stat_msgs)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_last = 1'b0; in1_last = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rdy(input bit port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port ? in1_ready : in0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL wait_ready%0d: ready stayed low, required 1 within 20 cycles", port);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'h61; in1_data = 8'h41;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({out_valid, out_data, out_last, out_src, err} !== 12'h000) begin
      errs++;
      $display("FAIL reset_out: got v=%b d=%h l=%b s=%b e=%b, required all 0",
               out_valid, out_data, out_last, out_src, err);
    end
    vecs++;
    if ({in0_ready, in1_ready} !== 2'b00) begin
      errs++;
      $display("FAIL reset_ready: got %b%b, required 00", in0_ready, in1_ready);
    end
    vecs++;
    if ({stat_conv, stat_msgs} !== 32'h0) begin
      errs++;
      $display("FAIL reset_stats: got %h/%h, required 0000/0000", stat_conv, stat_msgs);
    end
    apply_reset();
  endtask

  task automatic test_convert();
    bit ok;
    apply_reset();
    mode0 = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h61; in0_last = 1'b0;
    wait_rdy(1'b0, ok);
    @(negedge clk);
    vecs++;
    if ({out_valid, out_src, out_last, out_data} !== {3'b100, 8'h41}) begin
      errs++;
      $display("FAIL conv_a: got v%b s%b l%b %h, required v1 s0 l0 41",
               out_valid, out_src, out_last, out_data);
    end
    in0_data = 8'h5A;
    @(negedge clk);
    vecs++;
    if ({out_valid, out_src, out_last, out_data} !== {3'b100, 8'h5A}) begin
      errs++;
      $display("FAIL conv_Z: got v%b s%b l%b %h, required v1 s0 l0 5a",
               out_valid, out_src, out_last, out_data);
    end
    in0_data = 8'h7B; in0_last = 1'b1;
    @(negedge clk);
    vecs++;
    if ({out_valid, out_src, out_last, out_data} !== {3'b101, 8'h7B}) begin
      errs++;
      $display("FAIL conv_brace: got v%b s%b l%b %h, required v1 s0 l1 7b",
               out_valid, out_src, out_last, out_data);
    end
    vecs++;
    if (stat_conv !== (STATS_ON ? 16'd1 : 16'd0)) begin
      errs++;
      $display("FAIL conv_stat_conv: got %0d, required %0d", stat_conv, STATS_ON ? 1 : 0);
    end
    vecs++;
    if (stat_msgs !== (STATS_ON ? 16'd1 : 16'd0)) begin
      errs++;
      $display("FAIL conv_stat_msgs: got %0d, required %0d", stat_msgs, STATS_ON ? 1 : 0);
    end
    in0_valid = 1'b0; in0_last = 1'b0;
    @(negedge clk);
    vecs++;
    if ({out_valid, in0_ready} !== 2'b00) begin
      errs++;
      $display("FAIL conv_drain: got v%b rdy%b, required v0 rdy0", out_valid, in0_ready);
    end
  endtask

  task automatic test_round_robin();
    logic exp_v;
    logic exp_s;
    apply_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h30; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h31; in1_last = 1'b1;
    @(negedge clk);
    vecs++;
    if ({in0_ready, in1_ready} !== 2'b10) begin
      errs++;
      $display("FAIL rr_first_tie: got rdy %b%b, required 10", in0_ready, in1_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = ((k % 2) == 0);
      exp_s = ((k / 2) % 2) == 1;
      vecs++;
      if (out_valid !== exp_v ||
          (exp_v && ({out_src, out_last, out_data} !== {exp_s, 1'b1, (exp_s ? 8'h31 : 8'h30)}))) begin
        errs++;
        $display("FAIL rr_step%0d: got v%b s%b l%b %h, required v%b s%b l1", k,
                 out_valid, out_src, out_last, out_data, exp_v, exp_s);
      end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] src [4];
    logic [7:0] exp [4];
    int tx, rx;
    logic prev_ov, prev_or;
    logic [7:0] prev_od;
    src = '{8'h41, 8'h62, 8'h40, 8'h5B};
    exp = '{8'h61, 8'h62, 8'h40, 8'h5B};
    apply_reset();
    mode1 = 1'b0;
    tx = 0; rx = 0; prev_ov = 1'b0; prev_or = 1'b0; prev_od = 8'h00;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_ov && prev_or) begin
        vecs++;
        if ({out_src, out_last, out_data} !== {1'b1, 1'b0, 8'h00} &&
            0 == 1) begin
        end
        if ({prev_od} !== exp[rx]) begin
          errs++;
          $display("FAIL bp_byte%0d: got %h, required %h", rx, prev_od, exp[rx]);
        end
        rx++;
      end else if (prev_ov && !prev_or) begin
        vecs++;
        if ({out_valid, out_data} !== {1'b1, prev_od}) begin
          errs++;
          $display("FAIL bp_hold: got v%b %h, required v1 %h", out_valid, out_data, prev_od);
        end
      end
      out_ready = (c % 2) == 0;
      in1_valid = (tx < 4);
      in1_data  = (tx < 4) ? src[tx] : 8'h00;
      in1_last  = (tx == 3);
      #1;
      if (out_valid && out_ready) begin
        vecs++;
        if ({out_src, out_last} !== {1'b1, rx == 3}) begin
          errs++;
          $display("FAIL bp_tag%0d: got s%b l%b, required s1 l%b", rx, out_src, out_last, rx == 3);
        end
      end
      if (in1_valid && in1_ready) tx++;
      prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
    end
    vecs++;
    if (rx != 4 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_count: got %0d bytes, v%b after, required 4 bytes, v0", rx, out_valid);
    end
    in1_valid = 1'b0; in1_last = 1'b0;
  endtask

  task automatic test_watchdog();
    bit ok;
    apply_reset();
    mode0 = 1'b1; mode1 = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h20; in0_last = 1'b0;
    wait_rdy(1'b0, ok);
    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 8'h5A; in1_last = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vecs++;
      if ({err, in0_ready, in1_ready} !== 3'b010) begin
        errs++;
        $display("FAIL wd_idle%0d: got err%b rdy%b%b, required err0 rdy10", k, err, in0_ready, in1_ready);
      end
    end
    @(negedge clk);
    vecs++;
    if ({err, in0_ready, in1_ready, out_valid} !== 4'b1000) begin
      errs++;
      $display("FAIL wd_fire: got err%b rdy%b%b v%b, required err1 rdy00 v0",
               err, in0_ready, in1_ready, out_valid);
    end
    @(negedge clk);
    vecs++;
    if ({err, in0_ready, in1_ready} !== 3'b001) begin
      errs++;
      $display("FAIL wd_regrant: got err%b rdy%b%b, required err0 rdy01", err, in0_ready, in1_ready);
    end
    @(negedge clk);
    in1_valid = 1'b0; in1_last = 1'b0;
    vecs++;
    if ({out_valid, out_src, out_last, out_data} !== {3'b111, 8'h5A}) begin
      errs++;
      $display("FAIL wd_port1_byte: got v%b s%b l%b %h, required v1 s1 l1 5a",
               out_valid, out_src, out_last, out_data);
    end
    vecs++;
    if (stat_msgs !== (STATS_ON ? 16'd1 : 16'd0)) begin
      errs++;
      $display("FAIL wd_stat_msgs: got %0d, required %0d", stat_msgs, STATS_ON ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    mode0 = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h61; in0_last = 1'b0;
    wait_rdy(1'b0, ok);
    @(negedge clk);
    vecs++;
    if ({out_valid, out_data} !== {1'b1, 8'h41}) begin
      errs++;
      $display("FAIL rstmid_pre: got v%b %h, required v1 41", out_valid, out_data);
    end
    rst = 1'b1; in1_valid = 1'b1; in1_data = 8'h42; in1_last = 1'b1; in0_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vecs++;
    if ({out_valid, out_data, out_last, out_src, err, in0_ready, in1_ready} !== 14'h0) begin
      errs++;
      $display("FAIL rstmid_out: got v%b %h l%b s%b e%b rdy%b%b, required all 0",
               out_valid, out_data, out_last, out_src, err, in0_ready, in1_ready);
    end
    vecs++;
    if ({stat_conv, stat_msgs} !== 32'h0) begin
      errs++;
      $display("FAIL rstmid_stats: got %h/%h, required 0000/0000", stat_conv, stat_msgs);
    end
    @(negedge clk);
    vecs++;
    if ({in0_ready, in1_ready} !== 2'b10) begin
      errs++;
      $display("FAIL rstmid_tie: got rdy%b%b, required 10", in0_ready, in1_ready);
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
